dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage's data-memory interface. It takes the MEM stage's read/write strobes, byte address and write data, and returns read data.
- Contains a word-organised RAM and a wait-state FSM. The FSM asserts stall to freeze the pipeline until each access completes.
- Sits outside the core, directly on the dataAddr/wdata/mem_MemRead/mem_MemWrite/rdata wires.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- ADDR_W, 10, log2(DEPTH); word-index width.
- WAIT_CYCLES, 2, extra wait states per access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_MemRead  in  1  read request from the MEM stage.
- mem_MemWrite  in  1  write request from the MEM stage.
- dataAddr  in  32  byte address (`RegBus`).
- wdata  in  32  write data (`RegBus`).
- rdata  out  32  read data (`RegBus`), registered.
- stall  out  1  pipeline freeze request.
- addr_err  out  1  misaligned-access flag, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, wait counter=0, rdata=0, addr_err=0.
  - stall is forced 0 while rst=1.
  - RAM contents are not reset.
- Request definitions:
  - req = mem_MemRead | mem_MemWrite.
  - If both are high, the access is a write; the read is ignored and rdata holds its value.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - stall = req.
    - If req: load counter with WAIT_CYCLES and go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - stall = 1.
    - If counter==0: perform the access at this edge and go to DONE.
    - Otherwise decrement the counter.
  - DONE:
    - stall = 0; rdata/addr_err are valid.
    - The pipeline advances at this edge.
    - Always return to IDLE; DONE does not sample req.
- Latency: a request first visible in cycle 0 gives stall high in cycles 0..WAIT_CYCLES+1. Stall is low in cycle WAIT_CYCLES+2 (DONE), with data valid in that cycle.
- Back-to-back accesses: the next request is seen in IDLE in the cycle after DONE. There is no overlap.
- Master contract: the MEM stage holds dataAddr, wdata and the strobes stable while stall=1. The responder re-samples them at the access edge.
- Access edge:
  - index = dataAddr[ADDR_W+1:2]. Upper address bits are ignored, so the address space wraps modulo DEPTH words.
  - Write: mem[index] <= wdata; rdata unchanged.
  - Read: rdata <= mem[index].
  - addr_err <= (dataAddr[1:0] != 0).
- Misaligned access:
  - Same timing as an aligned access.
  - Write is suppressed.
  - Read returns rdata=0.
  - addr_err=1 in the DONE cycle.
- addr_err lifetime: holds its value until the next access edge.
- rdata lifetime: holds the last read value through subsequent IDLE, write and DONE cycles.
- Reset mid-operation: asserting rst in WAIT aborts the access. No write is committed and the FSM returns to IDLE.
- Request dropped in WAIT (protocol violation): the access edge samples the strobes. If none is high, no RAM access occurs and the FSM still passes through DONE.

Decomposition:
- Shared definitions package/include:
  - `RegBus`/`InstAddrBus` widths.
  - FSM state encodings DMEM_IDLE/DMEM_WAIT/DMEM_DONE (2-bit).
  - Default WAIT_CYCLES constant.
- One sub-module, dmem_ram: single-port synchronous RAM with DEPTH×32, write enable, registered read. It is instantiated by dmem_responder; the FSM and counter stay in the parent.

Test Plan:
- Reset: hold rst=1 mid-WAIT with a write pending, release, then read the same address -> the old value is returned. Outputs rdata=0, stall=0, addr_err=0 during reset.
- Single write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to 0x0000_0010.
  - Read 0x10 -> stall high for 4 cycles per access, then rdata=0xDEADBEEF in DONE with stall=0.
- WAIT_CYCLES=0: read -> stall high exactly 2 cycles. Back-to-back reads of 0x0 and 0x4 -> one IDLE-stall gap with no overlap; correct data is returned each time.
- Wrap-around, DEPTH=1024:
  - Write 0x1234_5678 to 0x0000_1004.
  - Read 0x0000_0004 -> 0x1234_5678.
- Misaligned write of 0xFFFF_FFFF to 0x0000_0022 -> addr_err=1 in DONE and RAM word 8 unchanged. A subsequent aligned read clears addr_err to 0.
- Simultaneous mem_MemRead=mem_MemWrite=1 writing 0xA5A5_A5A5 to 0x40 -> rdata keeps its prior value; a subsequent read of 0x40 returns 0xA5A5_A5A5.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared bus widths, FSM state encodings and default timing for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned RegBus              = 32;
    localparam int unsigned InstAddrBus         = 32;
    localparam int unsigned DMEM_CNT_W          = 4;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with write enable and a registered read port.
// The read register resets to zero and can be cleared synchronously; the array is not reset.
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] q
);

    logic [RegBus-1:0] mem [DEPTH];

    // Array write port, no reset on storage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: holds until the next read or clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (re) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM in front of a word RAM, freezing the
// pipeline with stall until each access completes.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_MemRead,
    input  logic              mem_MemWrite,
    input  logic [RegBus-1:0] dataAddr,
    input  logic [RegBus-1:0] wdata,
    output logic [RegBus-1:0] rdata,
    output logic              stall,
    output logic              addr_err
);

    dmem_state_e           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  req;
    logic                  acc_edge;
    logic                  aligned;
    logic                  ram_we;
    logic                  ram_re;
    logic                  ram_clr;
    logic [ADDR_W-1:0]     index;
    logic                  unused_addr_hi;

    assign req            = mem_MemRead | mem_MemWrite;
    assign aligned        = (dataAddr[1:0] == 2'b00);
    assign index          = dataAddr[ADDR_W+1:2];
    assign unused_addr_hi = ^dataAddr[RegBus-1:ADDR_W+2];

    // Access happens on the edge leaving WAIT with the counter exhausted.
    assign acc_edge = (state == DMEM_WAIT) && (cnt == '0);

    // A simultaneous read+write is treated as a write; misaligned accesses never touch the array.
    assign ram_we  = acc_edge & mem_MemWrite & aligned;
    assign ram_re  = acc_edge & mem_MemRead & ~mem_MemWrite & aligned;
    assign ram_clr = acc_edge & mem_MemRead & ~mem_MemWrite & ~aligned;

    // Freeze request: follows req in IDLE, held through WAIT, released in DONE.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                DMEM_IDLE: stall = req;
                DMEM_WAIT: stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // Wait-state FSM, counter and misalignment flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DMEM_IDLE;
            cnt      <= '0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (req) begin
                        cnt   <= DMEM_CNT_W'(WAIT_CYCLES);
                        state <= DMEM_WAIT;
                    end
                end
                DMEM_WAIT: begin
                    if (cnt == '0) begin
                        if (req) begin
                            addr_err <= ~aligned;
                        end
                        state <= DMEM_DONE;
                    end else begin
                        cnt <= cnt - DMEM_CNT_W'(1);
                    end
                end
                default: begin
                    state <= DMEM_IDLE;
                end
            endcase
        end
    end

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .addr  (index),
        .wdata (wdata),
        .q     (rdata)
    );

endmodule
